// File: rtl/assert_event_logger_if.sv
// Event stream from the logger to its consumer: FIFO head plus pop handshake.
interface assert_event_logger_if #(
  parameter int IDX_W = 9,
  parameter int TS_W  = 32
);
  logic             evt_vld;
  logic             evt_rdy;
  logic [IDX_W-1:0] evt_idx;
  logic [IDX_W:0]   evt_cnt;
  logic [TS_W-1:0]  evt_ts;

  modport master (output evt_vld, evt_idx, evt_cnt, evt_ts, input evt_rdy);
  modport slave  (input evt_vld, evt_idx, evt_cnt, evt_ts, output evt_rdy);
endinterface

// File: rtl/assert_event_logger.sv
// Captures qualified violation vectors as {lowest index, popcount, timestamp} into a DEPTH FIFO; head valid 1 cycle after capture.
// Full FIFO without same-cycle pop drops and counts the event. ASSERT_LOG_HALT_EN: halt after the first captured event.
module assert_event_logger #(
  parameter int VEC_W = 432,
  parameter int IDX_W = 9,
  parameter int DEPTH = 8,
  parameter int TS_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   arm,
  input  logic                   flag_vld,
  input  logic [VEC_W-1:0]       flag_vec,
  assert_event_logger_if.master  evt,
  output logic [15:0]            total_cnt,
  output logic [7:0]             drop_cnt,
  output logic                   first_vld,
  output logic [IDX_W-1:0]       first_idx,
  output logic [1:0]             state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_OCC = DEPTH[PTR_W:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   cnt;
    logic [TS_W-1:0]  ts;
  } entry_t;

  state_t           state_q, state_d;
  logic [TS_W-1:0]  ts_q;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   occ;

  logic [IDX_W-1:0] low_idx;
  logic [IDX_W:0]   pop_cnt;
  logic             any_set;
  logic             cap_evt;
  logic             push;
  logic             pop;
  logic             drop;

  always_comb begin
    low_idx = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (flag_vec[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < VEC_W; i++) begin
      pop_cnt = pop_cnt + (IDX_W+1)'(flag_vec[i]);
    end
  end

  assign any_set = |flag_vec;
  // clr wins over a same-cycle event and a same-cycle pop
  assign cap_evt = (state_q == ARMED) && flag_vld && any_set && !clr;
  assign pop     = evt.evt_vld && evt.evt_rdy && !clr;
  assign push    = cap_evt && ((occ != FULL_OCC) || pop);
  assign drop    = cap_evt && !push;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!clr && arm) state_d = ARMED;
      end
      ARMED: begin
        if (clr) state_d = IDLE;
`ifdef ASSERT_LOG_HALT_EN
        else if (cap_evt) state_d = HALTED;
`endif
      end
      HALTED: begin
        if (clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= '{idx: low_idx, cnt: pop_cnt, ts: ts_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      total_cnt <= '0;
      drop_cnt  <= '0;
      first_vld <= 1'b0;
      first_idx <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      total_cnt <= '0;
      drop_cnt  <= '0;
      first_vld <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (cap_evt && (total_cnt != 16'hFFFF)) total_cnt <= total_cnt + 1'b1;
      if (drop && (drop_cnt != 8'hFF))        drop_cnt  <= drop_cnt + 1'b1;
      if (cap_evt && !first_vld) begin
        first_vld <= 1'b1;
        first_idx <= low_idx;
      end
    end
  end

  assign evt.evt_vld = (occ != '0);
  assign evt.evt_idx = mem[rd_ptr].idx;
  assign evt.evt_cnt = mem[rd_ptr].cnt;
  assign evt.evt_ts  = mem[rd_ptr].ts;
  assign state       = state_q;

endmodule

// File: tb/tb_assert_event_logger.sv
// Directed bench for assert_event_logger; expected values are hand-derived, timestamps tracked by a local cycle counter.
module tb_assert_event_logger;
  localparam int VEC_W = 432;
  localparam int IDX_W = 9;
  localparam int DEPTH = 8;
  localparam int TS_W  = 32;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             arm;
  logic             flag_vld;
  logic [VEC_W-1:0] flag_vec;
  logic [15:0]      total_cnt;
  logic [7:0]       drop_cnt;
  logic             first_vld;
  logic [IDX_W-1:0] first_idx;
  logic [1:0]       state;

  assert_event_logger_if #(.IDX_W(IDX_W), .TS_W(TS_W)) ev ();

  assert_event_logger #(.VEC_W(VEC_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .arm       (arm),
    .flag_vld  (flag_vld),
    .flag_vec  (flag_vec),
    .evt       (ev),
    .total_cnt (total_cnt),
    .drop_cnt  (drop_cnt),
    .first_vld (first_vld),
    .first_idx (first_idx),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [31:0] tb_ts;
  logic [31:0] exp_ts [11];

  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    tb_ts = r ? 32'd0 : tb_ts + 32'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int e;
    checks   = 0;
    errors   = 0;
    tb_ts    = 0;
    rst      = 1'b1;
    clr      = 1'b0;
    arm      = 1'b0;
    flag_vld = 1'b0;
    flag_vec = '0;
    ev.evt_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_state", 32'(state), 0);
    chk("rst_evt_vld", 32'(ev.evt_vld), 0);
    chk("rst_total", 32'(total_cnt), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_first_vld", 32'(first_vld), 0);
    chk("rst_first_idx", 32'(first_idx), 0);

    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_state", 32'(state), 1);

    // single bit 28
    flag_vec = '0;
    flag_vec[28] = 1'b1;
    flag_vld = 1'b1;
    exp_ts[0] = tb_ts;
    tick();
    flag_vld = 1'b0;
    flag_vec = '0;
    chk("b28_vld", 32'(ev.evt_vld), 1);
    chk("b28_idx", 32'(ev.evt_idx), 28);
    chk("b28_cnt", 32'(ev.evt_cnt), 1);
    chk("b28_ts", 32'(ev.evt_ts), exp_ts[0]);
    chk("b28_first_vld", 32'(first_vld), 1);
    chk("b28_first_idx", 32'(first_idx), 28);
    chk("b28_total", 32'(total_cnt), 1);
`ifdef ASSERT_LOG_HALT_EN
    chk("b28_state", 32'(state), 2);
`else
    chk("b28_state", 32'(state), 1);
`endif
    tick();
    chk("hold_idx", 32'(ev.evt_idx), 28);
    chk("hold_vld", 32'(ev.evt_vld), 1);
    ev.evt_rdy = 1'b1;
    tick();
    ev.evt_rdy = 1'b0;
    chk("pop_empty", 32'(ev.evt_vld), 0);

    // bits 5, 100, 431
    clr = 1'b1;
    tick();
    clr = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    flag_vec = '0;
    flag_vec[5] = 1'b1;
    flag_vec[100] = 1'b1;
    flag_vec[431] = 1'b1;
    flag_vld = 1'b1;
    tick();
    chk("m3_idx", 32'(ev.evt_idx), 5);
    chk("m3_cnt", 32'(ev.evt_cnt), 3);
    chk("m3_first_idx", 32'(first_idx), 5);
    chk("m3_total", 32'(total_cnt), 1);
    flag_vld = 1'b0;
    tick();
    flag_vec = '0;
    flag_vld = 1'b1;
    tick();
    flag_vld = 1'b0;
    chk("unqual_total", 32'(total_cnt), 1);
    ev.evt_rdy = 1'b1;
    tick();
    ev.evt_rdy = 1'b0;
    chk("unqual_nopush", 32'(ev.evt_vld), 0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
`ifndef ASSERT_LOG_HALT_EN
    // overflow: 10 events into 8 entries
    flag_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      flag_vec = '0;
      flag_vec[i] = 1'b1;
      flag_vec[i+200] = 1'b1;
      exp_ts[i] = tb_ts;
      tick();
    end
    chk("ovf_total", 32'(total_cnt), 10);
    chk("ovf_drop", 32'(drop_cnt), 2);
    chk("ovf_head_idx", 32'(ev.evt_idx), 0);
    // full with simultaneous pop: push accepted
    flag_vec = '0;
    flag_vec[300] = 1'b1;
    ev.evt_rdy = 1'b1;
    exp_ts[10] = tb_ts;
    tick();
    flag_vld = 1'b0;
    flag_vec = '0;
    chk("fullpop_drop", 32'(drop_cnt), 2);
    chk("fullpop_total", 32'(total_cnt), 11);
    for (int k = 1; k <= 8; k++) begin
      e = (k == 8) ? 10 : k;
      chk("drain_vld", 32'(ev.evt_vld), 1);
      chk("drain_idx", 32'(ev.evt_idx), (e == 10) ? 32'd300 : 32'(e));
      chk("drain_cnt", 32'(ev.evt_cnt), (e == 10) ? 32'd1 : 32'd2);
      chk("drain_ts", 32'(ev.evt_ts), exp_ts[e]);
      tick();
    end
    ev.evt_rdy = 1'b0;
    chk("drain_empty", 32'(ev.evt_vld), 0);
    // drop counter saturation
    flag_vec[1] = 1'b1;
    flag_vld = 1'b1;
    for (int i = 0; i < 270; i++) tick();
    flag_vld = 1'b0;
    flag_vec = '0;
    chk("sat_drop", 32'(drop_cnt), 255);
    chk("sat_total", 32'(total_cnt), 281);
    chk("sat_state", 32'(state), 1);
`else
    flag_vec = '0;
    flag_vec[3] = 1'b1;
    flag_vld = 1'b1;
    tick();
    chk("halt_state", 32'(state), 2);
    tick();
    tick();
    flag_vld = 1'b0;
    flag_vec = '0;
    chk("halt_total", 32'(total_cnt), 1);
    chk("halt_drop", 32'(drop_cnt), 0);
    chk("halt_vld", 32'(ev.evt_vld), 1);
    ev.evt_rdy = 1'b1;
    tick();
    ev.evt_rdy = 1'b0;
    chk("halt_one_entry", 32'(ev.evt_vld), 0);
`endif

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_state", 32'(state), 0);
    chk("clr_vld", 32'(ev.evt_vld), 0);
    chk("clr_total", 32'(total_cnt), 0);
    chk("clr_drop", 32'(drop_cnt), 0);
    chk("clr_first_vld", 32'(first_vld), 0);

    // clr + arm + event in one cycle
    arm = 1'b1;
    tick();
    clr = 1'b1;
    flag_vec[7] = 1'b1;
    flag_vld = 1'b1;
    tick();
    clr = 1'b0;
    arm = 1'b0;
    flag_vld = 1'b0;
    flag_vec = '0;
    chk("cae_state", 32'(state), 0);
    chk("cae_vld", 32'(ev.evt_vld), 0);
    chk("cae_total", 32'(total_cnt), 0);
    chk("cae_first_vld", 32'(first_vld), 0);

    // reset mid-drain with an event in flight
    arm = 1'b1;
    tick();
    arm = 1'b0;
    flag_vec[9] = 1'b1;
    flag_vld = 1'b1;
    tick();
    tick();
    tick();
    ev.evt_rdy = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flag_vld = 1'b0;
    flag_vec = '0;
    chk("mrst_vld0", 32'(ev.evt_vld), 0);
    tick();
    chk("mrst_vld1", 32'(ev.evt_vld), 0);
    chk("mrst_total", 32'(total_cnt), 0);
    chk("mrst_drop", 32'(drop_cnt), 0);
    chk("mrst_first_vld", 32'(first_vld), 0);
    chk("mrst_first_idx", 32'(first_idx), 0);
    chk("mrst_state", 32'(state), 0);
    ev.evt_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
